gray_counter_n: RTL and testbench

//   Parametrised Gray-code counter with up/down direction, synchronous load,

---
 rtl/gray_counter_n.sv | 69 ++++++
 tb/tb_gray_counter_n.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_n.sv
// rtl/gray_counter_n.sv - parametrised up/down Gray counter with load, wrap/saturate, overflow
module gray_counter_n #(
  parameter int               WIDTH     = 3,
  parameter int               WRAP_MODE = 1,
  parameter logic [WIDTH-1:0] RST_BIN   = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             ClrOvf,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Bin,
  output logic             Overflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [WIDTH-1:0] bin_nxt;
  logic             evt;

  always_comb begin
    bin_nxt = Bin;
    evt     = 1'b0;
    if (Load) begin
      bin_nxt = LoadVal;
    end else if (En) begin
      if (Dir) begin
        if (Bin == BIN_MAX) begin
          evt = 1'b1;
          if (WRAP_MODE != 0) bin_nxt = '0;
        end else begin
          bin_nxt = Bin + BIN_ONE;
        end
      end else begin
        if (Bin == '0) begin
          evt = 1'b1;
          if (WRAP_MODE != 0) bin_nxt = BIN_MAX;
        end else begin
          bin_nxt = Bin - BIN_ONE;
        end
      end
    end
  end

  // Gray is derived from the next binary value so Output and Bin move on the same edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Bin      <= RST_BIN;
      Output   <= RST_GRAY;
      Overflow <= 1'b0;
      Wrap     <= 1'b0;
    end else begin
      Bin    <= bin_nxt;
      Output <= bin_nxt ^ (bin_nxt >> 1);
      Wrap   <= evt;
      if (evt)
        Overflow <= 1'b1;
      else if (ClrOvf)
        Overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_counter_n.sv
// tb/tb_gray_counter_n.sv - self-checking bench for gray_counter_n
module tb_gray_counter_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 3-bit duts (wrap, and saturate with RST_BIN=2) share one input set
  logic       en3, dir3, load3, clr3;
  logic [2:0] ld3;
  logic [2:0] g3, b3, gs, bs;
  logic       ov3, wr3, ovs, wrs;
  logic       en8, dir8, load8, clr8;
  logic [7:0] ld8, g8, b8;
  logic       ov8, wr8;

  gray_counter_n #(.WIDTH(3), .WRAP_MODE(1), .RST_BIN(3'd0)) dut3 (
    .Clk(clk), .Reset(rst), .En(en3), .Dir(dir3), .Load(load3), .LoadVal(ld3),
    .ClrOvf(clr3), .Output(g3), .Bin(b3), .Overflow(ov3), .Wrap(wr3));

  gray_counter_n #(.WIDTH(3), .WRAP_MODE(0), .RST_BIN(3'd2)) duts (
    .Clk(clk), .Reset(rst), .En(en3), .Dir(dir3), .Load(load3), .LoadVal(ld3),
    .ClrOvf(clr3), .Output(gs), .Bin(bs), .Overflow(ovs), .Wrap(wrs));

  gray_counter_n #(.WIDTH(8), .WRAP_MODE(1), .RST_BIN(8'd0)) dut8 (
    .Clk(clk), .Reset(rst), .En(en8), .Dir(dir8), .Load(load8), .LoadVal(ld8),
    .ClrOvf(clr8), .Output(g8), .Bin(b8), .Overflow(ov8), .Wrap(wr8));

  int checks = 0;
  int errors = 0;

  // reference state: plain integer counts
  int m3, ms, m8;
  bit mo3, mos, mo8, mw3, mws, mw8;

  typedef struct {
    logic       en, dir, load;
    logic [2:0] ldv;
    logic       clr;
    logic [2:0] gray, bin;
    logic       ovf, wrap;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int gray2bin(input int w, input int g);
    int b = 0;
    for (int i = w - 1; i >= 0; i--)
      b |= (((b >> (i + 1)) ^ (g >> i)) & 1) << i;
    return b;
  endfunction

  task automatic model_step(input int w, input bit wm, input bit en, input bit dir,
                            input bit load, input int ldv, input bit clr,
                            inout int b, inout bit ovf, output bit wr);
    int top = (1 << w) - 1;
    int t;
    wr = 1'b0;
    if (load) begin
      b = ldv;
    end else if (en) begin
      t = dir ? b + 1 : b - 1;
      if (t > top || t < 0) begin
        wr = 1'b1;
        if (wm) b = (t + top + 1) % (top + 1);
      end else begin
        b = t;
      end
    end
    if (wr) ovf = 1'b1;
    else if (clr) ovf = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input bit en, input bit dir, input bit load, input int ldv, input bit clr);
    en3 = en; dir3 = dir; load3 = load; ld3 = 3'(ldv); clr3 = clr;
    model_step(3, 1'b1, en, dir, load, ldv, clr, m3, mo3, mw3);
    model_step(3, 1'b0, en, dir, load, ldv, clr, ms, mos, mws);
  endtask

  task automatic check_s();
    chk("sat_bin", int'(bs), ms);
    chk("sat_gray", int'(gs), to_gray(ms));
    chk("sat_ovf", int'(ovs), int'(mos));
    chk("sat_wrap", int'(wrs), int'(mws));
  endtask

  task automatic model_reset();
    m3 = 0; ms = 2; m8 = 0;
    mo3 = 0; mos = 0; mo8 = 0; mw3 = 0; mws = 0; mw8 = 0;
  endtask

  initial begin
    bit step8, step3;
    int pg8, pg3;
    rst = 1'b1;
    en3 = 0; dir3 = 0; load3 = 0; ld3 = '0; clr3 = 0;
    en8 = 0; dir8 = 0; load8 = 0; ld8 = '0; clr8 = 0;
    model_reset();

    // wrap-mode expectations, starting from reset (B=0)
    tbl.push_back('{1, 1, 0, 3'd0, 0, 3'b001, 3'd1, 0, 0});
    tbl.push_back('{1, 1, 0, 3'd0, 0, 3'b011, 3'd2, 0, 0});
    tbl.push_back('{1, 1, 0, 3'd0, 0, 3'b010, 3'd3, 0, 0});
    tbl.push_back('{1, 1, 0, 3'd0, 0, 3'b110, 3'd4, 0, 0});
    tbl.push_back('{1, 1, 0, 3'd0, 0, 3'b111, 3'd5, 0, 0});
    tbl.push_back('{1, 1, 0, 3'd0, 0, 3'b101, 3'd6, 0, 0});
    tbl.push_back('{1, 1, 0, 3'd0, 0, 3'b100, 3'd7, 0, 0});
    tbl.push_back('{1, 1, 0, 3'd0, 0, 3'b000, 3'd0, 1, 1});
    tbl.push_back('{0, 1, 0, 3'd0, 0, 3'b000, 3'd0, 1, 0});
    tbl.push_back('{1, 0, 0, 3'd0, 0, 3'b100, 3'd7, 1, 1});
    tbl.push_back('{1, 0, 0, 3'd0, 0, 3'b101, 3'd6, 1, 0});
    tbl.push_back('{1, 0, 0, 3'd0, 0, 3'b111, 3'd5, 1, 0});
    tbl.push_back('{1, 0, 0, 3'd0, 0, 3'b110, 3'd4, 1, 0});
    tbl.push_back('{1, 1, 1, 3'd5, 0, 3'b111, 3'd5, 1, 0});
    tbl.push_back('{0, 1, 0, 3'd0, 1, 3'b111, 3'd5, 0, 0});
    tbl.push_back('{0, 1, 1, 3'd7, 0, 3'b100, 3'd7, 0, 0});
    tbl.push_back('{1, 1, 0, 3'd0, 1, 3'b000, 3'd0, 1, 1});
    tbl.push_back('{0, 1, 0, 3'd0, 0, 3'b000, 3'd0, 1, 0});
    tbl.push_back('{1, 0, 1, 3'd0, 0, 3'b000, 3'd0, 1, 0});
    tbl.push_back('{0, 0, 0, 3'd0, 1, 3'b000, 3'd0, 0, 0});

    #3;
    chk("rst_gray3", int'(g3), 0);
    chk("rst_bin3", int'(b3), 0);
    chk("rst_ovf3", int'(ov3), 0);
    chk("rst_wrap3", int'(wr3), 0);
    chk("rst_bin_s", int'(bs), 2);
    chk("rst_gray_s", int'(gs), 3);
    chk("rst_gray8", int'(g8), 0);
    #9 rst = 1'b0;

    foreach (tbl[i]) begin
      drive3(tbl[i].en, tbl[i].dir, tbl[i].load, int'(tbl[i].ldv), tbl[i].clr);
      tick();
      chk($sformatf("tbl%0d_gray", i), int'(g3), int'(tbl[i].gray));
      chk($sformatf("tbl%0d_bin", i), int'(b3), int'(tbl[i].bin));
      chk($sformatf("tbl%0d_ovf", i), int'(ov3), int'(tbl[i].ovf));
      chk($sformatf("tbl%0d_wrap", i), int'(wr3), int'(tbl[i].wrap));
      check_s();
    end

    // saturate: from RST_BIN=2 up to 7, then three blocked steps
    rst = 1'b1; #1; rst = 1'b0; model_reset();
    for (int i = 0; i < 5; i++) begin drive3(1, 1, 0, 0, 0); tick(); end
    chk("sat_top_bin", int'(bs), 7);
    chk("sat_top_wrap", int'(wrs), 0);
    for (int i = 0; i < 3; i++) begin
      drive3(1, 1, 0, 0, 0); tick();
      chk("sat_hold_gray", int'(gs), 3'b100);
      chk("sat_hold_wrap", int'(wrs), 1);
      chk("sat_hold_ovf", int'(ovs), 1);
    end
    drive3(0, 1, 0, 0, 0); tick();
    chk("sat_idle_wrap", int'(wrs), 0);
    chk("sat_idle_ovf", int'(ovs), 1);
    for (int i = 0; i < 8; i++) begin drive3(1, 0, 0, 0, 0); tick(); end
    check_s();

    // reset pulse between edges while counting
    drive3(1, 1, 0, 0, 0); en8 = 1; dir8 = 1; tick();
    #2 rst = 1'b1;
    #1;
    chk("async_bin3", int'(b3), 0);
    chk("async_gray_s", int'(gs), 3);
    chk("async_bin_s", int'(bs), 2);
    chk("async_ovf_s", int'(ovs), 0);
    chk("async_bin8", int'(b8), 0);
    #1 rst = 1'b0;
    model_reset();
    drive3(1, 1, 0, 0, 0);
    model_step(8, 1'b1, 1, 1, 0, 0, 0, m8, mo8, mw8);
    tick();
    chk("resume_bin3", int'(b3), 1);
    chk("resume_bin_s", int'(bs), 3);
    chk("resume_bin8", int'(b8), 1);

    // randomized run against the integer model
    for (int c = 0; c < 2000; c++) begin
      pg8 = int'(g8); pg3 = int'(g3);
      en8 = 1'($urandom); dir8 = 1'($urandom);
      load8 = ($urandom_range(0, 31) == 0); ld8 = 8'($urandom);
      clr8 = ($urandom_range(0, 7) == 0);
      model_step(8, 1'b1, en8, dir8, load8, int'(ld8), clr8, m8, mo8, mw8);
      step8 = en8 && !load8;
      drive3(1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0,
             int'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
      step3 = en3 && !load3;
      tick();
      chk("rnd_bin8", int'(b8), m8);
      chk("rnd_gray8", int'(g8), to_gray(m8));
      chk("rnd_g2b8", gray2bin(8, int'(g8)), int'(b8));
      chk("rnd_ovf8", int'(ov8), int'(mo8));
      chk("rnd_wrap8", int'(wr8), int'(mw8));
      if (step8) chk("rnd_hd8", $countones(8'(pg8) ^ g8), 1);
      chk("rnd_bin3", int'(b3), m3);
      chk("rnd_gray3", int'(g3), to_gray(m3));
      chk("rnd_ovf3", int'(ov3), int'(mo3));
      chk("rnd_wrap3", int'(wr3), int'(mw3));
      if (step3) chk("rnd_hd3", $countones(3'(pg3) ^ g3), 1);
      check_s();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
